// File: rtl/fp_unit_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fp_arb_pkg
// Shared types and width helpers for the floating-point unit arbiter.
//   state_t      : arbiter FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   idx_width()  : width of a requester index, $clog2(n) with a floor of 1
//   cnt_width()  : width of the WAIT-cycle timeout counter
// -----------------------------------------------------------------------------
package fp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // A single requester still needs a 1-bit index signal.
    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Counter must be able to represent TIMEOUT_CYCLES-1 (its last value).
    function automatic int cnt_width(input int timeout_cycles);
        return (timeout_cycles > 1) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/fp_unit_arbiter_if.sv
// -----------------------------------------------------------------------------
// fp_unit_arbiter_if
// Bundles the requester-side and unit-side handshakes of the arbiter.
//   Requester side : req_valid, req_operand_a/b (flattened, requester i at
//                    [i*DATA_WIDTH +: DATA_WIDTH]), req_grant, resp_valid,
//                    resp_data
//   Unit side      : unit_operand_a/b, unit_start, unit_result_ready,
//                    unit_result
//   Status         : busy, timeout_error
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters + shared unit)
// -----------------------------------------------------------------------------
interface fp_unit_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 3
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_b;
    logic [NUM_REQ-1:0]            req_grant;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic [DATA_WIDTH-1:0]         unit_operand_a;
    logic [DATA_WIDTH-1:0]         unit_operand_b;
    logic                          unit_start;
    logic                          unit_result_ready;
    logic [DATA_WIDTH-1:0]         unit_result;
    logic                          busy;
    logic                          timeout_error;

    modport slave (
        input  req_valid, req_operand_a, req_operand_b,
        input  unit_result_ready, unit_result,
        output req_grant, resp_valid, resp_data,
        output unit_operand_a, unit_operand_b, unit_start,
        output busy, timeout_error
    );

    modport master (
        output req_valid, req_operand_a, req_operand_b,
        output unit_result_ready, unit_result,
        input  req_grant, resp_valid, resp_data,
        input  unit_operand_a, unit_operand_b, unit_start,
        input  busy, timeout_error
    );
endinterface

// File: rtl/fp_unit_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select
// Combinational round-robin pick: scans req upward from ptr, wrapping modulo
// NUM_REQ, and reports the first set bit.
//   req       in  NUM_REQ  request vector
//   ptr       in  IDX_W    index with highest priority
//   winner    out IDX_W    selected index (0 when nothing requests)
//   any_valid out 1        at least one request bit set
// -----------------------------------------------------------------------------
module rr_priority_select
    import fp_arb_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    int idx;

    // NOTE: every variable assigned in always_comb gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        winner    = '0;
        any_valid = |req;
        idx       = 0;
        // Walk from the farthest position back toward ptr so the nearest set
        // bit is the last one written and therefore wins, without a break.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) winner = IDX_W'(idx);
        end
    end

endmodule

// File: rtl/fp_unit_arbiter.sv
// -----------------------------------------------------------------------------
// fp_unit_arbiter
// Shares one non-pipelined floating-point unit between NUM_REQ sequencers.
// Round-robin arbitration, operand latch, one-cycle start, single in-flight
// operation tracking, result routing back to the owner, and a WAIT timeout.
//   clock  in  1   rising-edge clock
//   reset  in  1   asynchronous, active-low
//   bus    slave   fp_unit_arbiter_if (requester, unit and status signals)
// All outputs are registered.
// -----------------------------------------------------------------------------
module fp_unit_arbiter
    import fp_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               clock,
    input logic               reset,
    fp_unit_arbiter_if.slave  bus
);

    localparam int              IDX_W    = idx_width(NUM_REQ);
    localparam int              CNT_W    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [CNT_W-1:0] wait_cnt;

    logic [IDX_W-1:0] winner;
    logic             any_valid;
    logic [IDX_W-1:0] next_ptr;

    logic [DATA_WIDTH-1:0] operand_a [NUM_REQ];
    logic [DATA_WIDTH-1:0] operand_b [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign operand_a[i] = bus.req_operand_a[i*DATA_WIDTH +: DATA_WIDTH];
        assign operand_b[i] = bus.req_operand_b[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_select #(
        .NUM_REQ (NUM_REQ)
    ) u_select (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Pointer moves just past the requester that was served.
    assign next_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    // NOTE: asynchronous reset is included in the sensitivity list so that
    // asserting reset clears every output at once, without waiting for clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            owner              <= '0;
            wait_cnt           <= '0;
            bus.req_grant      <= '0;
            bus.resp_valid     <= '0;
            bus.resp_data      <= '0;
            bus.unit_operand_a <= '0;
            bus.unit_operand_b <= '0;
            bus.unit_start     <= 1'b0;
            bus.busy           <= 1'b0;
            bus.timeout_error  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values; the pulse defaults below are
            // then overridden later in the block where a pulse is due.
            bus.req_grant  <= '0;
            bus.unit_start <= 1'b0;
            bus.resp_valid <= '0;
            bus.resp_data  <= '0;

            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner                 <= winner;
                        bus.unit_operand_a    <= operand_a[winner];
                        bus.unit_operand_b    <= operand_b[winner];
                        bus.req_grant[winner] <= 1'b1;
                        bus.unit_start        <= 1'b1;
                        bus.busy              <= 1'b1;
                        state                 <= ISSUE;
                    end else begin
                        bus.unit_operand_a <= '0;
                        bus.unit_operand_b <= '0;
                    end
                end

                // Start pulse is on the unit this cycle; a ready here cannot
                // belong to this operation, so it is ignored.
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end

                WAIT: begin
                    if (bus.unit_result_ready) begin
                        bus.resp_valid[owner] <= 1'b1;
                        bus.resp_data         <= bus.unit_result;
                        rr_ptr                <= next_ptr;
                        wait_cnt              <= '0;
                        bus.unit_operand_a    <= '0;
                        bus.unit_operand_b    <= '0;
                        bus.busy              <= 1'b0;
                        state                 <= IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Abort: owner still gets its response slot, with a
                        // zero result and the sticky error flag raised.
                        bus.resp_valid[owner] <= 1'b1;
                        bus.timeout_error     <= 1'b1;
                        rr_ptr                <= next_ptr;
                        wait_cnt              <= '0;
                        bus.unit_operand_a    <= '0;
                        bus.unit_operand_b    <= '0;
                        bus.busy              <= 1'b0;
                        state                 <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_unit_arbiter
// Directed bench for fp_unit_arbiter with NUM_REQ=3, TIMEOUT_CYCLES=8. Inputs
// are changed and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fp_unit_arbiter;

    localparam int DW = 32;
    localparam int NR = 3;
    localparam int TO = 8;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    fp_unit_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    fp_unit_arbiter #(
        .DATA_WIDTH     (DW),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [31:0] opa(input int i);
        return 32'h0000_1000 + i;
    endfunction

    function automatic logic [31:0] opb(input int i);
        return 32'h0000_2000 + i;
    endfunction

    // Called at the falling edge where the grant for requester idx should be
    // visible. Applies req_after, models a unit of latency lat returning res,
    // and checks the response lat+1 cycles after the grant.
    task automatic serve(input string tag, input int idx, input int lat,
                         input logic [31:0] res, input logic [31:0] ea,
                         input logic [31:0] eb, input logic [2:0] req_after);
        check({tag, "_grant"}, 32'(bus.req_grant), 32'(3'b001 << idx));
        check({tag, "_start"}, 32'(bus.unit_start), 32'd1);
        check({tag, "_opa"}, bus.unit_operand_a, ea);
        check({tag, "_opb"}, bus.unit_operand_b, eb);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        bus.req_valid = req_after;
        for (int c = 0; c < lat; c++) begin
            tick();
            check({tag, "_wait_resp"}, 32'(bus.resp_valid), 32'd0);
            check({tag, "_wait_start"}, 32'(bus.unit_start), 32'd0);
            check({tag, "_wait_opa"}, bus.unit_operand_a, ea);
        end
        bus.unit_result_ready = 1'b1;
        bus.unit_result       = res;
        tick();
        bus.unit_result_ready = 1'b0;
        bus.unit_result       = '0;
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'(3'b001 << idx));
        check({tag, "_resp_data"}, bus.resp_data, res);
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        errors                = 0;
        checks                = 0;
        reset                 = 1'b0;
        bus.req_valid         = '0;
        bus.req_operand_a     = {opa(2), opa(1), opa(0)};
        bus.req_operand_b     = {opb(2), opb(1), opb(0)};
        bus.unit_result_ready = 1'b0;
        bus.unit_result       = '0;

        // Reset state
        tick();
        check("rst_grant", 32'(bus.req_grant), 32'd0);
        check("rst_resp", 32'(bus.resp_valid), 32'd0);
        check("rst_start", 32'(bus.unit_start), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_toerr", 32'(bus.timeout_error), 32'd0);
        check("rst_opa", bus.unit_operand_a, 32'd0);

        // All three requesting continuously from reset, latency 2
        bus.req_valid = 3'b111;
        tick();
        reset = 1'b1;
        tick();
        serve("rr0", 0, 2, 32'h100, opa(0), opb(0), 3'b111);
        tick();
        serve("rr1", 1, 2, 32'h101, opa(1), opb(1), 3'b111);
        tick();
        serve("rr2", 2, 2, 32'h102, opa(2), opb(2), 3'b111);
        tick();
        serve("rr3", 0, 2, 32'h100, opa(0), opb(0), 3'b000);
        check("rr_ptr_after_rr", 32'(dut.rr_ptr), 32'd1);

        // Requests 0 and 2 with rr_ptr=1: requester 2 wins first
        bus.req_valid = 3'b101;
        tick();
        serve("ptr_a", 2, 2, 32'h55, opa(2), opb(2), 3'b001);
        check("rr_ptr_a", 32'(dut.rr_ptr), 32'd0);
        tick();
        serve("ptr_b", 0, 2, 32'h66, opa(0), opb(0), 3'b000);
        check("rr_ptr_b", 32'(dut.rr_ptr), 32'd1);

        // Single request with floating-point operands, unit latency 4
        bus.req_operand_a = {opa(2), 32'h3F80_0000, opa(0)};
        bus.req_operand_b = {opb(2), 32'h4000_0000, opb(0)};
        bus.req_valid     = 3'b010;
        tick();
        serve("single", 1, 4, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000);
        tick();
        check("single_busy_after", 32'(bus.busy), 32'd0);
        check("single_resp_after", 32'(bus.resp_valid), 32'd0);
        check("single_opa_idle", bus.unit_operand_a, 32'd0);
        bus.req_operand_a = {opa(2), opa(1), opa(0)};
        bus.req_operand_b = {opb(2), opb(1), opb(0)};

        // Timeout: unit never answers (rr_ptr=2, only requester 0 asks)
        bus.req_valid = 3'b001;
        tick();
        check("to_grant", 32'(bus.req_grant), 32'b001);
        bus.req_valid = 3'b000;
        for (int c = 0; c < TO; c++) begin
            tick();
            check("to_wait_resp", 32'(bus.resp_valid), 32'd0);
            check("to_wait_err", 32'(bus.timeout_error), 32'd0);
        end
        tick();
        check("to_resp_valid", 32'(bus.resp_valid), 32'b001);
        check("to_resp_data", bus.resp_data, 32'd0);
        check("to_err", 32'(bus.timeout_error), 32'd1);
        check("to_busy", 32'(bus.busy), 32'd0);
        check("to_rr_ptr", 32'(dut.rr_ptr), 32'd1);

        // Successful op afterwards; error flag stays set
        bus.req_valid = 3'b010;
        tick();
        serve("post_to", 1, 1, 32'h77, opa(1), opb(1), 3'b000);
        check("post_to_err", 32'(bus.timeout_error), 32'd1);

        // Spurious ready in IDLE
        bus.unit_result_ready = 1'b1;
        bus.unit_result       = 32'hDEAD;
        tick();
        bus.unit_result_ready = 1'b0;
        bus.unit_result       = '0;
        check("spur_idle_resp", 32'(bus.resp_valid), 32'd0);
        check("spur_idle_busy", 32'(bus.busy), 32'd0);

        // Spurious ready in ISSUE (latency 0), then resolved by timeout
        bus.req_valid = 3'b100;
        tick();
        check("spur_iss_grant", 32'(bus.req_grant), 32'b100);
        bus.req_valid         = 3'b000;
        bus.unit_result_ready = 1'b1;
        bus.unit_result       = 32'hBEEF;
        tick();
        bus.unit_result_ready = 1'b0;
        bus.unit_result       = '0;
        check("spur_iss_resp", 32'(bus.resp_valid), 32'd0);
        check("spur_iss_busy", 32'(bus.busy), 32'd1);
        for (int c = 0; c < TO - 1; c++) begin
            tick();
            check("spur_iss_wait", 32'(bus.resp_valid), 32'd0);
        end
        tick();
        check("spur_iss_to_resp", 32'(bus.resp_valid), 32'b100);
        check("spur_iss_to_data", bus.resp_data, 32'd0);

        // Bring rr_ptr to 2, then start an op and reset during WAIT
        bus.req_valid = 3'b010;
        tick();
        serve("pre_rst", 1, 1, 32'h88, opa(1), opb(1), 3'b000);
        check("pre_rst_ptr", 32'(dut.rr_ptr), 32'd2);
        bus.req_valid = 3'b001;
        tick();
        check("rw_grant", 32'(bus.req_grant), 32'b001);
        bus.req_valid = 3'b000;
        tick();
        tick();
        check("rw_busy", 32'(bus.busy), 32'd1);
        check("rw_err_set", 32'(bus.timeout_error), 32'd1);
        reset = 1'b0;
        #1;
        check("rw_busy_clr", 32'(bus.busy), 32'd0);
        check("rw_err_clr", 32'(bus.timeout_error), 32'd0);
        check("rw_opa_clr", bus.unit_operand_a, 32'd0);
        check("rw_opb_clr", bus.unit_operand_b, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        bus.unit_result_ready = 1'b1;
        bus.unit_result       = 32'hCAFE;
        tick();
        bus.unit_result_ready = 1'b0;
        bus.unit_result       = '0;
        check("rw_no_resp", 32'(bus.resp_valid), 32'd0);
        tick();
        check("rw_no_resp2", 32'(bus.resp_valid), 32'd0);

        // rr_ptr back at 0: requests 1 and 2 -> requester 1 wins
        bus.req_valid = 3'b110;
        tick();
        serve("after_rst", 1, 2, 32'h99, opa(1), opb(1), 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
